pc_trap_ctrl: RTL and testbench
===============================

// Module: pc_trap_ctrl
// PURPOSE
//  Sequences the PC-select mux (PCSrc) of the CPU_PC next-PC unit.
//  Merges the decoder's normal choice with illegal-opcode traps and external interrupts.
//  Tracks user/kernel mode, captures EPC on entry, returns on ERET and masks IRQs for a holdoff window.
//  Sits between the control decoder and CPU_PC; drives CPU_PC.PCSrc.
// PARAMETERS
//  IRQ_HOLDOFF  1   cycles after ERET during which IRQ stays masked (0 = none)
//  CNT_W        4   holdoff counter width; IRQ_HOLDOFF < 2**CNT_W
// PORTS
//  clk          in   1   system clock, rising edge
//  reset        in   1   synchronous, active-high
//  dec_pcsrc    in   3   decoder choice: 000 PC+4, 001 branch, 010 jump, 011 jr
//  instr_valid  in   1   current slot holds a real instruction
//  illop        in   1   current instruction is an illegal opcode (qualified by instr_valid)
//  eret         in   1   current instruction is a return-from-exception (jr $k0)
//  irq          in   1   level interrupt request, async-free (already synchronised)
//  pc           in   32  PC of current instruction
//  pcsrc        out  3   to CPU_PC: 000..011 pass-through, 100 ILLOP vector, 101 XADR (IRQ) vector
//  epc          out  32  saved return address
//  epc_we       out  1   one-cycle strobe: epc loaded this edge
//  flush        out  1   kill the current instruction's writeback (trap cycle)
//  irq_ack      out  1   one-cycle pulse when the IRQ is taken
//  kernel       out  1   1 while in KERNEL state
//  double_fault out  1   sticky; set by illop while in KERNEL
// BEHAVIOUR
//  Reset (sync): state=USER, pending=0, cnt=0, epc=0, double_fault=0.
//   Registered outputs therefore read 0 the cycle after reset.
//   Combinational outputs follow state; with no trap pending: pcsrc=dec_pcsrc, flush=0, epc_we=0, irq_ack=0.
//  pending: set when irq=1 in any state; cleared only by an IRQ trap or by reset.
//   Deasserting irq does not clear it.
//  Trap decision, combinational per cycle, only when instr_valid=1:
//   illop wins over IRQ; IRQ wins over dec_pcsrc.
//  States: USER, KERNEL, HOLD.
//  USER:
//   illop -> pcsrc=100, flush=1, epc<=pc+4, epc_we=1; next KERNEL.
//   else pending -> pcsrc=101, flush=1, epc<=pc (instruction re-executed), epc_we=1, irq_ack=1, pending<=0; next KERNEL.
//   else pcsrc=dec_pcsrc (eret in USER is an ordinary jr).
//  KERNEL (kernel=1):
//   IRQ masked; pending may still set.
//   illop -> pcsrc=100, flush=1, double_fault<=1, epc NOT written; stay KERNEL.
//   eret -> pcsrc=011; if IRQ_HOLDOFF=0 next USER, else cnt<=IRQ_HOLDOFF-1 and next HOLD.
//   else pcsrc=dec_pcsrc.
//  HOLD:
//   Same as USER except the IRQ trap is suppressed.
//   illop traps as in USER (next KERNEL, cnt cleared).
//   cnt==0 -> next USER; else cnt<=cnt-1.
//  instr_valid=0: no trap, no state change except the HOLD countdown; pcsrc=dec_pcsrc.
//  Same-cycle illop+pending in USER: ILLOP taken, pending kept; IRQ is taken after return.
//  epc arithmetic: pc+4 mod 2**32 (wraps at 0xFFFFFFFC).
//  Reset during KERNEL/HOLD: returns to USER, drops pending, clears double_fault.
//  Latency: traps redirect pcsrc in the same cycle; state, epc and pending update on the next edge.
// TESTING
//  T1 reset, dec_pcsrc=010, no events -> pcsrc=010, kernel=0, epc=0, double_fault=0
//  T2 USER, pc=0x00000040, illop=1 -> pcsrc=100, flush=1, epc_we=1; next cycle epc=0x00000044, kernel=1
//  T3 USER, irq pulse 1 cycle, pc=0x00000100 -> pcsrc=101, irq_ack=1; next cycle epc=0x00000100, kernel=1
//  T4 KERNEL, irq=1, then eret (IRQ_HOLDOFF=1) -> pcsrc=011; 1 cycle HOLD with no IRQ trap; following cycle pcsrc=101
//  T5 KERNEL, illop=1 -> pcsrc=100, double_fault=1, epc unchanged; reset -> double_fault=0, state USER
//  T6 USER, illop=1 and irq=1 same cycle -> pcsrc=100; pending held; after eret+holdoff -> pcsrc=101

Source files
------------

// File: rtl/pc_trap_ctrl.sv
// pc_trap_ctrl: selects CPU_PC next-PC source, merging decoder choice with illegal-op traps and IRQs
module pc_trap_ctrl #(
  parameter int IRQ_HOLDOFF = 1,
  parameter int CNT_W = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  dec_pcsrc,
  input  logic        instr_valid,
  input  logic        illop,
  input  logic        eret,
  input  logic        irq,
  input  logic [31:0] pc,
  output logic [2:0]  pcsrc,
  output logic [31:0] epc,
  output logic        epc_we,
  output logic        flush,
  output logic        irq_ack,
  output logic        kernel,
  output logic        double_fault
);
  typedef enum logic [1:0] {USER, KERNEL, HOLD} state_t;
  localparam logic [CNT_W-1:0] HO_LOAD = CNT_W'(IRQ_HOLDOFF - 1);
  state_t           state;
  logic             pending;
  logic [CNT_W-1:0] cnt;
  logic             take_ill, take_irq, do_eret;
  // a request arriving this cycle is taken immediately, not one cycle later
  always_comb begin
    take_ill = instr_valid & illop;
    take_irq = instr_valid & ~illop & (pending | irq) & (state == USER);
    do_eret  = instr_valid & ~illop & eret & (state == KERNEL);
    pcsrc    = take_ill ? 3'b100 : take_irq ? 3'b101 : do_eret ? 3'b011 : dec_pcsrc;
    flush    = take_ill | take_irq;
    epc_we   = take_irq | (take_ill & (state != KERNEL));
    irq_ack  = take_irq;
    kernel   = (state == KERNEL);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= USER;
      pending      <= 1'b0;
      cnt          <= '0;
      epc          <= '0;
      double_fault <= 1'b0;
    end else begin
      pending <= take_irq ? 1'b0 : (pending | irq);
      if (epc_we) epc <= take_irq ? pc : pc + 32'd4;
      if (take_ill && state == KERNEL) double_fault <= 1'b1;
      if (take_ill || take_irq) begin
        state <= KERNEL;
        cnt   <= '0;
      end else if (do_eret) begin
        state <= (IRQ_HOLDOFF == 0) ? USER : HOLD;
        cnt   <= HO_LOAD;
      end else if (state == HOLD) begin
        if (cnt == '0) state <= USER;
        else cnt <= cnt - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_pc_trap_ctrl.sv
// tb_pc_trap_ctrl: scoreboard bench; a reference model queues expected outputs per driven cycle
module tb_pc_trap_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  dec_pcsrc = '0;
  logic        instr_valid = 1'b0, illop = 1'b0, eret = 1'b0, irq = 1'b0;
  logic [31:0] pc = '0;
  logic [2:0]  pcsrc;
  logic [31:0] epc;
  logic        epc_we, flush, irq_ack, kernel, double_fault;

  pc_trap_ctrl #(.IRQ_HOLDOFF(1), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .dec_pcsrc(dec_pcsrc), .instr_valid(instr_valid),
    .illop(illop), .eret(eret), .irq(irq), .pc(pc), .pcsrc(pcsrc), .epc(epc),
    .epc_we(epc_we), .flush(flush), .irq_ack(irq_ack), .kernel(kernel),
    .double_fault(double_fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  pcsrc;
    logic        flush, we, ack, kernel, df;
    logic [31:0] epc;
  } exp_t;
  exp_t q[$];
  int vecs = 0, errs = 0;

  localparam int U = 0, K = 1, H = 2;
  int          m_state = U, n_state = U;
  logic        m_pend = 0, n_pend = 0, m_df = 0, n_df = 0;
  logic [31:0] m_epc = 0, n_epc = 0;
  int          m_cnt = 0, n_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic rst();
    @(posedge clk); #1;
    reset = 1; instr_valid = 0; illop = 0; eret = 0; irq = 0;
    n_state = U; n_pend = 0; n_df = 0; n_epc = 0; n_cnt = 0;
  endtask

  task automatic cyc(input logic v, input logic ill, input logic er, input logic ir,
                     input logic [31:0] p, input logic [2:0] dec);
    exp_t e;
    @(posedge clk); #1;
    m_state = n_state; m_pend = n_pend; m_df = n_df; m_epc = n_epc; m_cnt = n_cnt;
    reset = 0; instr_valid = v; illop = ill; eret = er; irq = ir; pc = p; dec_pcsrc = dec;
    e.pcsrc = dec; e.flush = 0; e.we = 0; e.ack = 0;
    e.kernel = (m_state == K); e.df = m_df; e.epc = m_epc;
    n_pend = m_pend | ir;
    if (v && m_state == U && ill) begin
      e.pcsrc = 3'b100; e.flush = 1; e.we = 1; n_epc = p + 32'd4; n_state = K;
    end else if (v && m_state == U && (m_pend | ir)) begin
      e.pcsrc = 3'b101; e.flush = 1; e.we = 1; e.ack = 1; n_epc = p; n_pend = 0; n_state = K;
    end else if (v && m_state == K && ill) begin
      e.pcsrc = 3'b100; e.flush = 1; n_df = 1;
    end else if (v && m_state == K && er) begin
      e.pcsrc = 3'b011; n_state = H; n_cnt = 0;
    end else if (v && m_state == H && ill) begin
      e.pcsrc = 3'b100; e.flush = 1; e.we = 1; n_epc = p + 32'd4; n_state = K; n_cnt = 0;
    end else if (m_state == H) begin
      if (m_cnt == 0) n_state = U; else n_cnt = m_cnt - 1;
    end
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      chk("pcsrc", {29'd0, pcsrc}, {29'd0, e.pcsrc});
      chk("flush", {31'd0, flush}, {31'd0, e.flush});
      chk("epc_we", {31'd0, epc_we}, {31'd0, e.we});
      chk("irq_ack", {31'd0, irq_ack}, {31'd0, e.ack});
      chk("kernel", {31'd0, kernel}, {31'd0, e.kernel});
      chk("double_fault", {31'd0, double_fault}, {31'd0, e.df});
      chk("epc", epc, e.epc);
    end
  end

  initial begin
    rst();
    cyc(1, 0, 0, 0, 32'h0, 3'b010);
    cyc(1, 1, 0, 0, 32'h40, 3'b000);
    cyc(1, 0, 0, 0, 32'h80, 3'b001);
    cyc(1, 0, 1, 0, 32'h84, 3'b011);
    cyc(1, 0, 0, 0, 32'h44, 3'b000);
    cyc(1, 0, 0, 0, 32'h48, 3'b000);
    cyc(1, 0, 0, 1, 32'h100, 3'b001);
    cyc(1, 0, 0, 0, 32'h200, 3'b000);
    cyc(1, 0, 0, 1, 32'h204, 3'b000);
    cyc(1, 0, 0, 0, 32'h208, 3'b000);
    cyc(1, 0, 1, 0, 32'h20c, 3'b011);
    cyc(1, 0, 0, 0, 32'h100, 3'b000);
    cyc(1, 0, 0, 0, 32'h104, 3'b000);
    cyc(1, 0, 0, 0, 32'h200, 3'b000);
    cyc(1, 1, 0, 0, 32'h204, 3'b000);
    cyc(1, 0, 0, 0, 32'h208, 3'b000);
    rst();
    cyc(1, 0, 0, 0, 32'h0, 3'b001);
    cyc(1, 1, 0, 1, 32'h300, 3'b000);
    cyc(1, 0, 0, 0, 32'h200, 3'b000);
    cyc(1, 0, 1, 0, 32'h204, 3'b011);
    cyc(1, 0, 0, 0, 32'h304, 3'b000);
    cyc(1, 0, 0, 0, 32'h308, 3'b000);
    cyc(1, 0, 0, 1, 32'h200, 3'b000);
    rst();
    cyc(1, 0, 0, 0, 32'h0, 3'b000);
    cyc(0, 1, 0, 1, 32'h10, 3'b010);
    cyc(1, 0, 0, 0, 32'h14, 3'b000);
    rst();
    cyc(1, 1, 0, 0, 32'hFFFFFFFC, 3'b000);
    cyc(1, 0, 1, 0, 32'h200, 3'b011);
    cyc(0, 1, 0, 0, 32'h0, 3'b001);
    cyc(1, 1, 0, 0, 32'h8, 3'b000);
    cyc(1, 0, 1, 0, 32'h204, 3'b011);
    for (int i = 0; i < 400; i++)
      cyc(($urandom_range(0, 7) != 0), ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 9) == 0), $urandom, 3'($urandom_range(0, 3)));
    @(posedge clk); #1;
    instr_valid = 0;
    repeat (2) @(negedge clk);
    chk("drain", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
